serial_frame_ctrl: RTL
======================

SERIAL_FRAME_CTRL -- requirements
Module: serial_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: frame length in bits (2..32).
REQ-002 SHALL have parameter LAT, default 0: cycles from ser_in applied to matching ser_out valid in the serial unit (0..7).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  requester offers a frame on data_in.
REQ-006 SHALL have port in_ready  output  1  controller can accept a frame.
REQ-007 SHALL have port data_in  input  WIDTH  frame to serialise.
REQ-008 SHALL have port ser_in  output  1  bit driven to the serial unit's in.
REQ-009 SHALL have port ser_out  input  1  bit returned by the serial unit's out.
REQ-010 SHALL have port result  output  WIDTH  collected response frame.
REQ-011 SHALL have port done  output  1  one-cycle pulse: result updated.
REQ-012 SHALL have port busy  output  1  frame in flight.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE: in_ready=1, busy=0, ser_in=0; on edge with in_valid&&in_ready, latch data_in, clear bit counter, go RUN.
REQ-015 RUN: in_ready=0, busy=1; counter counts 0..WIDTH+LAT-1, one step per cycle.
REQ-016 RUN, counter k<WIDTH: ser_in = latched bit WIDTH-1-k (MSB first); k>=WIDTH: ser_in=0 (drain).
REQ-017 RUN: on each edge with counter >= LAT, shift ser_out into the capture register LSB; exactly WIDTH captures per frame.
REQ-018 RUN: on edge with counter = WIDTH+LAT-1, copy the completed capture into result and go DONE.
REQ-019 DONE: done=1, busy=0, in_ready=0 for exactly one cycle, then IDLE.
REQ-020 done SHALL therefore be high in the cycle after the (WIDTH+LAT)-th rising edge following the acceptance edge.
REQ-021 result SHALL hold its value from DONE until the next frame's DONE; never changes mid-frame.
REQ-022 in_valid during RUN/DONE SHALL be ignored; data_in changes after acceptance SHALL not affect the frame.
REQ-023 Earliest re-acceptance: the first IDLE cycle after DONE (throughput one frame per WIDTH+LAT+2 cycles).
REQ-024 Counter SHALL be sized for WIDTH+LAT without wrap; no counts beyond WIDTH+LAT-1.

Reset
REQ-025 reset high SHALL immediately, independent of clk, force IDLE, counter=0, capture=0, latched frame=0.
REQ-026 Reset values: in_ready=1, ser_in=0, result=0, done=0, busy=0 (parity=0 when present).
REQ-027 Reset mid-RUN SHALL abort the frame without a done pulse; result stays 0 until a later complete frame.

Configuration
REQ-028 Macro SERIAL_FRAME_PARITY_EN defined: extra output port parity (1 bit) = XOR of all bits of result, registered and updated together with result.
REQ-029 Macro undefined: no parity port, no parity logic; all other behaviour identical.

Verification
REQ-030 WIDTH=8, LAT=0, identity model (ser_out=ser_in): accept 0xA5 -> done 8 edges after acceptance edge, result=0xA5.
REQ-031 WIDTH=8, LAT=2, two-flop delay model: accept 0x5A -> done 10 edges after acceptance edge, result=0x5A, ser_in=0 during the 2 drain cycles.
REQ-032 WIDTH=8, LAT=0, inverter model: accept 0x3C -> result=0xC3; next frame 0xFF -> result=0x00, 0xC3 held until that done.
REQ-033 in_valid held high with 0x11 then 0x22: in_ready low from acceptance to end of DONE; 0x22 accepted in first IDLE cycle; results 0x11, 0x22 in order.
REQ-034 Assert reset at counter=4 of frame 0xA5: all outputs at reset values immediately, no done pulse, in_ready=1; frame 0x0F after release -> result=0x0F.
REQ-035 SERIAL_FRAME_PARITY_EN defined, identity model: frame 0x07 -> parity=1; frame 0x03 -> parity=0.

Source files
------------

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: serialises a WIDTH-bit frame MSB first into an external serial unit and collects WIDTH response bits
//   clk, reset (async, active-high) | in_valid/in_ready/data_in: frame request handshake
//   ser_in/ser_out: bit to/from the serial unit (LAT cycles apart) | result/done: response frame and its one-cycle pulse
//   busy: frame in flight | parity (only with SERIAL_FRAME_PARITY_EN): XOR of result, updated with result
module serial_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_in,
  input  logic             ser_out,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
`ifdef SERIAL_FRAME_PARITY_EN
  ,
  output logic             parity
`endif
);
  localparam int CW = $clog2(WIDTH + LAT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] frame, cap, shifted;
  logic last, cap_en;
  assign shifted = {cap[WIDTH-2:0], ser_out};
  assign last = cnt == CW'(WIDTH + LAT - 1);
  // capture starts once the first returned bit has come back through the unit's latency
  assign cap_en = (cnt + CW'(1)) > CW'(LAT);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    in_ready = state == IDLE;
    busy = state == RUN;
    done = state == DONE;
    // the latched frame shifts left with zero fill, so its MSB is the next bit and reads 0 while draining
    ser_in = busy & frame[WIDTH-1];
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      frame <= '0;
      cap <= '0;
      result <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      cnt <= '0;
      frame <= data_in;
      cap <= '0;
    end else if (state == RUN) begin
      frame <= frame << 1;
      if (!last) cnt <= cnt + CW'(1);
      if (cap_en) cap <= shifted;
      if (last) result <= shifted;
`ifdef SERIAL_FRAME_PARITY_EN
      if (last) parity <= ^shifted;
`endif
    end
endmodule
